// File: rtl/buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_pkg
//  Brief    : Shared helpers for circular-buffer users: parameter legality
//             checks and the modulo-DEPTH pointer wrap.
//  Revision : 1.0 - initial release
// ============================================================================
package buffer_pkg;

   // True when v is a non-zero power of two.
   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   // Legal controller configuration: every width/step fits inside the buffer
   // and a read never retires more words than its window covers.
   function automatic bit params_legal(input int unsigned depth,
                                       input int unsigned par_write,
                                       input int unsigned par_read,
                                       input int unsigned stride,
                                       input int unsigned addr_width);
      return (depth >= 2) &&
             (par_write >= 1) && (par_write <= depth) &&
             (par_read  >= 1) && (par_read  <= depth) &&
             (stride    >= 1) && (stride    <= par_read) &&
             (addr_width >= $clog2(depth)) && (addr_width <= 32);
   endfunction

   // Advance a pointer by inc modulo depth. ptr < depth and inc <= depth, so
   // the sum stays below 2*depth: a power-of-two depth wraps by masking off
   // the carry bits, any other depth needs at most one subtract.
   function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
      int unsigned sum;
      sum = ptr + inc;
      if (is_pow2(depth)) begin
         return sum & (depth - 1);
      end
      return (sum >= depth) ? (sum - depth) : sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_controller_if
//  Brief    : Producer/consumer handshake plus buffer address/status bus of
//             the circular-buffer controller. master = controller side,
//             slave = the environment (producer, consumer, buffer memory).
//  Revision : 1.0 - initial release
// ============================================================================
interface buffer_controller_if #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic                  flush;
   logic                  wr_valid;
   logic                  wr_ready;
   logic                  rd_valid;
   logic                  rd_ready;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;

   modport master (
      input  flush, wr_valid, rd_ready,
      output wr_ready, rd_valid, wen, waddr, raddr, count, full, empty
   );

   modport slave (
      output flush, wr_valid, rd_ready,
      input  wr_ready, rd_valid, wen, waddr, raddr, count, full, empty
   );
endinterface
`default_nettype wire

// File: rtl/circ_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : circ_ptr
//  Brief    : Modulo-DEPTH pointer advancing by INC on each enabled cycle,
//             with synchronous reset and synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module circ_ptr
   import buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned INC   = 1,
   parameter int unsigned WIDTH = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             clear,
   input  wire logic             en,
   output logic      [WIDTH-1:0] ptr
);

   generate
      if ((DEPTH < 2) || (INC < 1) || (INC > DEPTH) ||
          (WIDTH < $clog2(DEPTH)) || (WIDTH > 32)) begin : g_bad_params
         $fatal(1, "circ_ptr: illegal DEPTH/INC/WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] ptr_nxt;

   // Next pointer value one step ahead, always kept below DEPTH.
   always_comb begin
      ptr_nxt = WIDTH'(ptr_wrap(32'(ptr), INC, DEPTH));
   end

   // Pointer register: reset beats clear, clear beats advance.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/buffer_controller.sv
`default_nettype none
// ============================================================================
//  Module   : buffer_controller
//  Brief    : Pointer/occupancy controller for a circular buffer taking
//             PAR_WRITE words per write and presenting a PAR_READ-word window
//             that retires STRIDE words per read.
//  Revision : 1.0 - initial release
// ============================================================================
module buffer_controller
   import buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned PAR_WRITE  = 1,
   parameter int unsigned PAR_READ   = 1,
   parameter int unsigned STRIDE     = 1,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  wire logic           clk,
   input  wire logic           rst,
   buffer_controller_if.master bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   generate
      if (!params_legal(DEPTH, PAR_WRITE, PAR_READ, STRIDE, ADDR_WIDTH)) begin : g_bad_params
         $fatal(1, "buffer_controller: illegal parameter combination");
      end
   endgenerate

   logic [CW-1:0]         count_q;
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic                  wr_ready;
   logic                  rd_valid;
   logic                  wfire;
   logic                  rfire;

   // Handshake: space/data checks against the registered count; flush blocks
   // both sides so nothing fires in a clearing cycle.
   always_comb begin
      wr_ready = !bus.flush && ((CW'(DEPTH) - count_q) >= CW'(PAR_WRITE));
      rd_valid = !bus.flush && (count_q >= CW'(PAR_READ));
      wfire    = bus.wr_valid && wr_ready;
      rfire    = bus.rd_ready && rd_valid;
   end

   // Bus outputs: pointers go straight to the buffer, which wraps its own
   // read window; status flags follow the registered count.
   always_comb begin
      bus.wr_ready = wr_ready;
      bus.rd_valid = rd_valid;
      bus.wen      = wfire;
      bus.waddr    = wptr;
      bus.raddr    = rptr;
      bus.count    = count_q;
      bus.full     = (count_q == CW'(DEPTH));
      bus.empty    = (count_q == '0);
   end

   // Occupancy: both fires may land in one cycle. The ready/valid checks keep
   // the final value in 0..DEPTH, so modular intermediate math is harmless.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         count_q <= '0;
      end else begin
         count_q <= count_q
                    + (wfire ? CW'(PAR_WRITE) : CW'(0))
                    - (rfire ? CW'(STRIDE)    : CW'(0));
      end
   end

   circ_ptr #(
      .DEPTH (DEPTH),
      .INC   (PAR_WRITE),
      .WIDTH (ADDR_WIDTH)
   ) u_wptr (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.flush),
      .en    (wfire),
      .ptr   (wptr)
   );

   circ_ptr #(
      .DEPTH (DEPTH),
      .INC   (STRIDE),
      .WIDTH (ADDR_WIDTH)
   ) u_rptr (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.flush),
      .en    (rfire),
      .ptr   (rptr)
   );

endmodule
`default_nettype wire
